// File: rtl/mem_arbiter.sv
// Arbitrates the I-cache and D-cache line requests onto one shared memory port.
// Define ARB_ROUND_ROBIN_EN for alternating grants; otherwise D has priority, and I wins after D_BURST_MAX D grants.
module mem_arbiter #(
    parameter int LINE_W      = 128,
    parameter int D_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              mem_read_I,
    input  logic              mem_write_I,
    input  logic [31:4]       mem_addr_I,
    input  logic [LINE_W-1:0] mem_wdata_I,
    output logic [LINE_W-1:0] mem_rdata_I,
    output logic              mem_ready_I,

    input  logic              mem_read_D,
    input  logic              mem_write_D,
    input  logic [31:4]       mem_addr_D,
    input  logic [LINE_W-1:0] mem_wdata_D,
    output logic [LINE_W-1:0] mem_rdata_D,
    output logic              mem_ready_D,

    output logic              mem_read,
    output logic              mem_write,
    output logic [31:4]       mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,

    output logic [1:0]        owner
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE_I = 2'b01,
        SERVE_D = 2'b10
    } state_t;

    state_t state;

    logic pend_i;
    logic pend_d;
    logic grant_i;
    logic grant_d;

    assign pend_i = mem_read_I | mem_write_I;
    assign pend_d = mem_read_D | mem_write_D;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when the most recent grant went to D; on a tie the other side wins.
    logic last_d;
`else
    localparam int CNT_W = (D_BURST_MAX > 0) ? $clog2(D_BURST_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(D_BURST_MAX);

    logic [CNT_W-1:0] d_count;
    logic             i_starved;

    assign i_starved = pend_i & (d_count == BURST_LIMIT);
`endif

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_d = pend_d & (~pend_i | ~last_d);
`else
            grant_d = pend_d & ~i_starved;
`endif
            grant_i = pend_i & ~grant_d;
        end
    end

    // Gating with rst ensures an abandoned transaction never reports completion.
    assign mem_ready_I = (state == SERVE_I) & mem_ready & ~rst;
    assign mem_ready_D = (state == SERVE_D) & mem_ready & ~rst;
    assign mem_rdata_I = mem_rdata;
    assign mem_rdata_D = mem_rdata;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_d) begin
                        state     <= SERVE_D;
                        owner     <= SERVE_D;
                        mem_read  <= mem_read_D;
                        mem_write <= mem_write_D;
                        mem_addr  <= mem_addr_D;
                        mem_wdata <= mem_wdata_D;
                    end else if (grant_i) begin
                        state     <= SERVE_I;
                        owner     <= SERVE_I;
                        mem_read  <= mem_read_I;
                        mem_write <= mem_write_I;
                        mem_addr  <= mem_addr_I;
                        mem_wdata <= mem_wdata_I;
                    end
                end
                SERVE_I, SERVE_D: begin
                    // addr and wdata keep their last values while idle.
                    if (mem_ready) begin
                        state     <= IDLE;
                        owner     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    owner     <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_d <= 1'b0;
        end else if (grant_d) begin
            last_d <= 1'b1;
        end else if (grant_i) begin
            last_d <= 1'b0;
        end
    end
`else
    // Counts D grants that made a waiting I wait; a D grant with I idle restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_count <= '0;
        end else if (grant_i) begin
            d_count <= '0;
        end else if (grant_d) begin
            if (!pend_i) begin
                d_count <= '0;
            end else if (d_count != BURST_LIMIT) begin
                d_count <= d_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;

    localparam int LW          = 128;
    localparam int D_BURST_MAX = 4;

    logic          clk = 1'b0;
    logic          rst;

    logic          mem_read_I, mem_write_I;
    logic [31:4]   mem_addr_I;
    logic [LW-1:0] mem_wdata_I, mem_rdata_I;
    logic          mem_ready_I;

    logic          mem_read_D, mem_write_D;
    logic [31:4]   mem_addr_D;
    logic [LW-1:0] mem_wdata_D, mem_rdata_D;
    logic          mem_ready_D;

    logic          mem_read, mem_write;
    logic [31:4]   mem_addr;
    logic [LW-1:0] mem_wdata, mem_rdata;
    logic          mem_ready;
    logic [1:0]    owner;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.LINE_W(LW), .D_BURST_MAX(D_BURST_MAX)) dut (
        .clk(clk), .rst(rst),
        .mem_read_I(mem_read_I), .mem_write_I(mem_write_I), .mem_addr_I(mem_addr_I),
        .mem_wdata_I(mem_wdata_I), .mem_rdata_I(mem_rdata_I), .mem_ready_I(mem_ready_I),
        .mem_read_D(mem_read_D), .mem_write_D(mem_write_D), .mem_addr_D(mem_addr_D),
        .mem_wdata_D(mem_wdata_D), .mem_rdata_D(mem_rdata_D), .mem_ready_D(mem_ready_D),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .owner(owner)
    );

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic idle_inputs();
        mem_read_I  = 1'b0; mem_write_I = 1'b0; mem_addr_I = '0; mem_wdata_I = '0;
        mem_read_D  = 1'b0; mem_write_D = 1'b0; mem_addr_D = '0; mem_wdata_D = '0;
        mem_ready   = 1'b0; mem_rdata   = '0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level reference model ----------------
    int            m_owner;     // 0 idle, 1 I, 2 D
    bit            m_read, m_write;
    logic [31:4]   m_addr;
    logic [LW-1:0] m_wdata;
    int            m_streak;    // D grants in a row while I was waiting
    bit            m_last_d;    // last grant went to D

    function automatic void model_edge(output bit done_i, output bit done_d);
        bit ip, dp;
        int win;
        done_i = (m_owner == 1) && mem_ready && !rst;
        done_d = (m_owner == 2) && mem_ready && !rst;
        ip = mem_read_I || mem_write_I;
        dp = mem_read_D || mem_write_D;
        win = 0;
        if (rst) begin
            m_owner = 0; m_read = 0; m_write = 0; m_addr = '0; m_wdata = '0;
            m_streak = 0; m_last_d = 0;
        end else if (m_owner == 0) begin
            if (ip && dp) begin
`ifdef ARB_ROUND_ROBIN_EN
                win = m_last_d ? 1 : 2;
`else
                win = (m_streak == D_BURST_MAX) ? 1 : 2;
`endif
            end else if (ip) begin
                win = 1;
            end else if (dp) begin
                win = 2;
            end
            if (win == 1) begin
                m_streak = 0;
                m_read = mem_read_I; m_write = mem_write_I; m_addr = mem_addr_I; m_wdata = mem_wdata_I;
            end else if (win == 2) begin
                m_streak = ip ? ((m_streak < D_BURST_MAX) ? m_streak + 1 : m_streak) : 0;
                m_read = mem_read_D; m_write = mem_write_D; m_addr = mem_addr_D; m_wdata = mem_wdata_D;
            end
            if (win != 0) begin
                m_owner  = win;
                m_last_d = (win == 2);
            end
        end else if (mem_ready) begin
            m_owner = 0; m_read = 0; m_write = 0;
        end
    endfunction

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (owner !== 2'b00) begin errors++; $display("FAIL reset_owner got=%b want=00", owner); end
        checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL reset_rw got=%b want=00", {mem_read, mem_write}); end
        checks++; if (mem_addr !== 28'h0) begin errors++; $display("FAIL reset_addr got=%h want=0", mem_addr); end
        checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL reset_wdata got=%h want=0", mem_wdata); end
        checks++; if ({mem_ready_I, mem_ready_D} !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b want=00", {mem_ready_I, mem_ready_D}); end
    endtask

    task automatic test_lone_i();
        int pulses_i, pulses_d;
        int exp_owner;
        pulses_i = 0; pulses_d = 0;
        next_cycle();
        mem_ready = 1'b0; mem_read_I = 1'b1; mem_addr_I = 28'h0000100; mem_wdata_I = rand_line();
        @(negedge clk);
        checks++; if ({owner, mem_read} !== 3'b000) begin errors++; $display("FAIL lone_i_cycle0 got=%b want=000", {owner, mem_read}); end
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            mem_ready = (k == 3) || (k == 5);
            if (k == 4) mem_read_I = 1'b0;
            @(negedge clk);
            pulses_i += int'(mem_ready_I);
            pulses_d += int'(mem_ready_D);
            exp_owner = (k <= 3) ? 1 : 0;
            checks++; if (owner !== 2'(exp_owner)) begin errors++; $display("FAIL lone_i_owner k=%0d got=%b want=%0d", k, owner, exp_owner); end
            checks++; if (mem_read !== (k <= 3)) begin errors++; $display("FAIL lone_i_read k=%0d got=%b want=%b", k, mem_read, (k <= 3)); end
        end
        checks++; if (pulses_i != 1) begin errors++; $display("FAIL lone_i_pulses got=%0d want=1", pulses_i); end
        checks++; if (pulses_d != 0) begin errors++; $display("FAIL lone_i_d_pulses got=%0d want=0", pulses_d); end
        checks++; if (mem_addr !== 28'h0000100) begin errors++; $display("FAIL lone_i_addr_hold got=%h want=0000100", mem_addr); end
    endtask

    task automatic test_both_pending();
        int            exp_owner [4] = '{2, 0, 1, 0};
        logic [LW-1:0] a5;
        a5 = {(LW / 8){8'hA5}};
        next_cycle();
        mem_ready = 1'b0;
        mem_read_I = 1'b1; mem_addr_I = 28'h0000300; mem_wdata_I = rand_line();
        mem_write_D = 1'b1; mem_addr_D = 28'h0000200; mem_wdata_D = a5;
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            mem_ready = (k == 1) || (k == 3);
            mem_rdata = rand_line();
            if (k == 2) mem_write_D = 1'b0;
            if (k == 4) mem_read_I = 1'b0;
            @(negedge clk);
            checks++; if (owner !== 2'(exp_owner[k-1])) begin errors++; $display("FAIL both_owner k=%0d got=%b want=%0d", k, owner, exp_owner[k-1]); end
            if (k == 1) begin
                checks++; if ({mem_read, mem_write} !== 2'b01) begin errors++; $display("FAIL both_d_rw got=%b want=01", {mem_read, mem_write}); end
                checks++; if (mem_addr !== 28'h0000200) begin errors++; $display("FAIL both_d_addr got=%h want=0000200", mem_addr); end
                checks++; if (mem_wdata !== a5) begin errors++; $display("FAIL both_d_wdata got=%h want=%h", mem_wdata, a5); end
                checks++; if ({mem_ready_I, mem_ready_D} !== 2'b01) begin errors++; $display("FAIL both_d_ready got=%b want=01", {mem_ready_I, mem_ready_D}); end
                checks++; if (mem_rdata_D !== mem_rdata || mem_rdata_I !== mem_rdata) begin errors++; $display("FAIL both_rdata got=%h/%h want=%h", mem_rdata_I, mem_rdata_D, mem_rdata); end
            end
            if (k == 3) begin
                checks++; if ({mem_read, mem_write} !== 2'b10) begin errors++; $display("FAIL both_i_rw got=%b want=10", {mem_read, mem_write}); end
                checks++; if (mem_addr !== 28'h0000300) begin errors++; $display("FAIL both_i_addr got=%h want=0000300", mem_addr); end
                checks++; if ({mem_ready_I, mem_ready_D} !== 2'b10) begin errors++; $display("FAIL both_i_ready got=%b want=10", {mem_ready_I, mem_ready_D}); end
            end
        end
    endtask

    task automatic test_burst_order();
        int   grants[$];
        int   exp_order[$];
        logic [1:0] prev;
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{2, 1, 2, 1};
`else
        exp_order = '{2, 2, 2, 2, 1};
`endif
        prev = 2'b00;
        next_cycle();
        mem_read_I = 1'b1; mem_addr_I = 28'h0000600;
        mem_read_D = 1'b1; mem_addr_D = 28'h0000700;
        mem_ready  = 1'b1;
        for (int n = 0; n < 60 && grants.size() < exp_order.size(); n++) begin
            next_cycle();
            @(negedge clk);
            if (owner != 2'b00 && prev == 2'b00) grants.push_back(int'(owner));
            prev = owner;
        end
        checks++; if (grants.size() != exp_order.size()) begin errors++; $display("FAIL burst_count got=%0d want=%0d", grants.size(), exp_order.size()); end
        for (int g = 0; g < exp_order.size() && g < grants.size(); g++) begin
            checks++; if (grants[g] != exp_order[g]) begin errors++; $display("FAIL burst_grant[%0d] got=%0d want=%0d", g, grants[g], exp_order[g]); end
        end
        next_cycle();
        mem_read_I = 1'b0; mem_read_D = 1'b0;
        repeat (3) next_cycle();
        mem_ready = 1'b0;
    endtask

    task automatic test_reset_mid_serve();
        next_cycle();
        mem_read_D = 1'b1; mem_addr_D = 28'h0000400; mem_wdata_D = rand_line();
        next_cycle();
        @(negedge clk);
        checks++; if (owner !== 2'b10) begin errors++; $display("FAIL rst_mid_owner_pre got=%b want=10", owner); end
        next_cycle();
        rst = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        checks++; if ({mem_ready_I, mem_ready_D} !== 2'b00) begin errors++; $display("FAIL rst_mid_ready_during got=%b want=00", {mem_ready_I, mem_ready_D}); end
        next_cycle();
        rst = 1'b0; mem_read_D = 1'b0;
        @(negedge clk);
        checks++; if (owner !== 2'b00) begin errors++; $display("FAIL rst_mid_owner got=%b want=00", owner); end
        checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL rst_mid_rw got=%b want=00", {mem_read, mem_write}); end
        checks++; if (mem_addr !== 28'h0 || mem_wdata !== '0) begin errors++; $display("FAIL rst_mid_addr_wdata got=%h/%h want=0/0", mem_addr, mem_wdata); end
        checks++; if ({mem_ready_I, mem_ready_D} !== 2'b00) begin errors++; $display("FAIL rst_mid_ready_after got=%b want=00", {mem_ready_I, mem_ready_D}); end
        next_cycle();
        mem_ready = 1'b0;
    endtask

    task automatic test_addr_change();
        logic [LW-1:0] w;
        w = rand_line();
        next_cycle();
        mem_write_D = 1'b1; mem_addr_D = 28'h0000500; mem_wdata_D = w;
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            if (k <= 3) begin mem_addr_D = 28'($urandom); mem_wdata_D = rand_line(); end
            mem_ready = (k == 3);
            if (k == 4) mem_write_D = 1'b0;
            @(negedge clk);
            checks++; if (mem_addr !== 28'h0000500) begin errors++; $display("FAIL addr_hold k=%0d got=%h want=0000500", k, mem_addr); end
            if (k <= 3) begin
                checks++; if (mem_wdata !== w) begin errors++; $display("FAIL wdata_hold k=%0d got=%h want=%h", k, mem_wdata, w); end
            end
            if (k == 3) begin
                checks++; if (mem_ready_D !== 1'b1) begin errors++; $display("FAIL addr_change_ready got=%b want=1", mem_ready_D); end
            end
        end
    endtask

    // ---------------- randomized traffic ----------------
    task automatic test_random();
        bit done_i, done_d, act_i, act_d;
        bit exp_ri, exp_rd;
        act_i = 0; act_d = 0;
        idle_inputs();
        next_cycle();
        rst = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk);
            model_edge(done_i, done_d);
            #1;
            rst = ($urandom_range(0, 199) == 0);
            if (done_i) begin act_i = 0; mem_read_I = 0; mem_write_I = 0; end
            if (done_d) begin act_d = 0; mem_read_D = 0; mem_write_D = 0; end
            if (!act_i && $urandom_range(0, 3) == 0) begin
                act_i = 1; mem_read_I = $urandom_range(0, 1); mem_write_I = !mem_read_I;
                mem_addr_I = 28'($urandom); mem_wdata_I = rand_line();
            end else if (act_i && m_owner == 1 && $urandom_range(0, 3) == 0) begin
                mem_addr_I = 28'($urandom); mem_wdata_I = rand_line();
            end
            if (!act_d && $urandom_range(0, 2) == 0) begin
                act_d = 1; mem_read_D = $urandom_range(0, 1); mem_write_D = !mem_read_D;
                mem_addr_D = 28'($urandom); mem_wdata_D = rand_line();
            end else if (act_d && m_owner == 2 && $urandom_range(0, 3) == 0) begin
                mem_addr_D = 28'($urandom); mem_wdata_D = rand_line();
            end
            mem_ready = ($urandom_range(0, 2) == 0);
            mem_rdata = rand_line();
            @(negedge clk);
            exp_ri = (m_owner == 1) && mem_ready && !rst;
            exp_rd = (m_owner == 2) && mem_ready && !rst;
            checks++; if ({owner, mem_read, mem_write} !== {2'(m_owner), m_read, m_write}) begin
                errors++; $display("FAIL rand_ctrl n=%0d got=%b want=%b", n, {owner, mem_read, mem_write}, {2'(m_owner), m_read, m_write});
            end
            checks++; if (mem_addr !== m_addr) begin errors++; $display("FAIL rand_addr n=%0d got=%h want=%h", n, mem_addr, m_addr); end
            checks++; if (mem_wdata !== m_wdata) begin errors++; $display("FAIL rand_wdata n=%0d got=%h want=%h", n, mem_wdata, m_wdata); end
            checks++; if ({mem_ready_I, mem_ready_D} !== {exp_ri, exp_rd}) begin
                errors++; $display("FAIL rand_ready n=%0d got=%b want=%b", n, {mem_ready_I, mem_ready_D}, {exp_ri, exp_rd});
            end
            checks++; if (mem_rdata_I !== mem_rdata || mem_rdata_D !== mem_rdata) begin
                errors++; $display("FAIL rand_rdata n=%0d got=%h/%h want=%h", n, mem_rdata_I, mem_rdata_D, mem_rdata);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_lone_i();
        test_both_pending();
        test_burst_order();
        test_reset_mid_serve();
        test_addr_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter LINE_W, default 128: cache-line width in bits for all rdata/wdata ports.
REQ-002 The block SHALL have parameter D_BURST_MAX, default 4: the most consecutive D grants allowed while I is pending.
REQ-003 The block SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 The block SHALL have ports mem_read_I, mem_write_I  input  1 each: I-cache line read/write request, held until its ready.
REQ-006 The block SHALL have ports mem_addr_I  input  [31:4] and mem_wdata_I  input  LINE_W: the I-cache line address and write data.
REQ-007 The block SHALL have ports mem_rdata_I  output  LINE_W and mem_ready_I  output  1: I-cache read data and completion strobe.
REQ-008 The block SHALL have ports mem_read_D, mem_write_D, mem_addr_D, mem_wdata_D, mem_rdata_D, mem_ready_D: the D-cache equivalents, with the same directions and widths as the I-cache ports.
REQ-009 The block SHALL have ports mem_read, mem_write  output  1 each; mem_addr  output  [31:4]; mem_wdata  output  LINE_W: the shared memory request.
REQ-010 The block SHALL have ports mem_rdata  input  LINE_W and mem_ready  input  1: the shared memory response.
REQ-011 The block SHALL have port owner  output  2: 00 = idle, 01 = I granted, 10 = D granted.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, SERVE_I and SERVE_D.
REQ-013 A requester SHALL count as pending when its read or its write input is 1.
REQ-014 In IDLE, if any requester is pending, the block SHALL choose a winner and enter SERVE_I or SERVE_D at the next edge; if none is pending, it SHALL stay in IDLE.
REQ-015 On a grant, the block SHALL latch the winner's read, write, addr and wdata into registers that drive mem_read, mem_write, mem_addr and mem_wdata for the whole SERVE state; later input changes SHALL be ignored.
REQ-016 In IDLE, mem_read and mem_write SHALL be 0, and mem_addr and mem_wdata SHALL hold their last values.
REQ-017 In SERVE_x, mem_ready SHALL be routed combinationally to mem_ready_x only; the other cache's ready SHALL be 0.
REQ-018 mem_rdata SHALL be broadcast combinationally to both mem_rdata_I and mem_rdata_D.
REQ-019 In SERVE_x with mem_ready = 1, the block SHALL return to IDLE at the next edge; a SERVE state SHALL never go directly to another SERVE state.
REQ-020 Arbitration overhead SHALL be exactly 1 cycle: a request seen in IDLE at cycle t appears on the memory port at cycle t+1, and 1 IDLE cycle follows each completion.
REQ-021 Fixed policy: when both are pending, D SHALL win, unless the consecutive-D counter equals D_BURST_MAX, in which case I SHALL win.
REQ-022 The consecutive-D counter SHALL increment on each D grant made while I is pending, saturating at D_BURST_MAX.
REQ-023 The consecutive-D counter SHALL clear on any I grant, and on any D grant made while I is idle.
REQ-024 A lone pending requester SHALL always be granted, whatever the counter value.
REQ-025 mem_ready = 1 while in IDLE SHALL be ignored: no ready output asserts and no state changes.
REQ-026 owner SHALL be a registered output encoding the current state.

Reset
REQ-027 When rst = 1 at an edge, the block SHALL enter IDLE and clear mem_read, mem_write, mem_addr, mem_wdata, owner, the consecutive-D counter and the last-owner flag to 0.
REQ-028 Reset during SERVE_x SHALL abandon the transaction with no ready pulse to either cache.
REQ-029 The ready outputs SHALL be 0 in the cycle after a reset edge.

Configuration
REQ-030 With macro ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL go to the requester not served last, using a last-owner flag whose reset value is I, so D wins first; D_BURST_MAX and the consecutive-D counter SHALL then be unused.
REQ-031 With ARB_ROUND_ROBIN_EN undefined, the fixed policy of REQ-021 to REQ-024 SHALL apply.

Verification
REQ-032 Lone I read, addr 0x0000100, memory ready after 3 cycles -> mem_read=1 from cycle 1, mem_ready_I pulses once, mem_ready_D stays 0, owner 01 then 00.
REQ-033 I and D both pending (D write, addr 0x0000200, wdata 0xA5..A5) -> D served first with mem_write=1 and the latched wdata, then I served after 1 IDLE cycle.
REQ-034 D pending continuously and I pending, D_BURST_MAX=4, macro undefined -> grant order D,D,D,D,I.
REQ-035 With ARB_ROUND_ROBIN_EN defined and both pending continuously -> grant order D,I,D,I.
REQ-036 rst pulsed while in SERVE_D -> next cycle IDLE, all memory outputs 0, no ready pulse to either cache.
REQ-037 D changes mem_addr_D mid-SERVE_D -> mem_addr holds the originally latched value until completion.
